// File: rtl/mesh_loader.sv
// Streams {addr,data} packets into N PE slots, commits the frame, then sorts.
// Optional duplicate-address check: define MESH_LOADER_DUP_CHECK_EN.
module mesh_loader #(
  parameter int N           = 64,
  parameter int SQRT_N      = 8,
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 6,
  parameter int SORT_CYCLES = 53,
  parameter int WIDTH       = ADDR_WIDTH + DATA_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_pkt,
  output logic [N*WIDTH-1:0] load_bus,
  output logic               load_en,
  output logic               sort_en,
  output logic               done,
  output logic               busy,
  output logic               dup_err
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(SORT_CYCLES + 1);

  if (SQRT_N * SQRT_N != N) begin : g_bad_side
    $error("mesh_loader: SQRT_N*SQRT_N must equal N");
  end

  typedef enum logic [1:0] {
    FILL,
    COMMIT,
    SORT,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N*WIDTH-1:0] bus_q, bus_d;
  logic               accept;

  assign in_ready = (state_q == FILL);
  assign accept   = in_valid && in_ready;
  assign load_bus = bus_q;
  assign load_en  = (state_q == COMMIT);
  assign sort_en  = (state_q == SORT);
  assign done     = (state_q == DONE);
  assign busy     = (state_q != FILL);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    bus_d   = bus_q;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          // Packet order, not its addr field, selects the slot.
          bus_d[idx_q*WIDTH +: WIDTH] = in_pkt;
          if (idx_q == IDX_W'(N - 1)) begin
            idx_d   = '0;
            state_d = COMMIT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      COMMIT: begin
        cnt_d   = '0;
        state_d = SORT;
      end
      SORT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(SORT_CYCLES - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = FILL;
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      cnt_q   <= '0;
      bus_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      bus_q   <= bus_d;
    end
  end

`ifdef MESH_LOADER_DUP_CHECK_EN
  logic [N-1:0]          seen_q, seen_d;
  logic                  dup_q, dup_d;
  logic [ADDR_WIDTH-1:0] pkt_addr;
  logic                  addr_oob;
  logic                  addr_hit;

  assign pkt_addr = in_pkt[WIDTH-1:DATA_WIDTH];
  assign addr_oob = (32'(pkt_addr) >= N);
  assign dup_err  = dup_q;

  always_comb begin
    seen_d   = seen_q;
    dup_d    = dup_q;
    addr_hit = 1'b0;
    if (!addr_oob) begin
      addr_hit = seen_q[pkt_addr];
    end
    if (accept) begin
      if (!addr_oob) begin
        seen_d[pkt_addr] = 1'b1;
      end
      // First accept of a frame drops the previous frame's flag.
      dup_d = ((idx_q == '0) ? 1'b0 : dup_q) | addr_oob | addr_hit;
    end
    if (state_q == DONE) begin
      seen_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seen_q <= '0;
      dup_q  <= 1'b0;
    end else begin
      seen_q <= seen_d;
      dup_q  <= dup_d;
    end
  end
`else
  assign dup_err = 1'b0;
`endif

endmodule

// File: tb/tb_mesh_loader.sv
// Directed self-checking bench for mesh_loader (default parameters).
// Covers reset, frame timing, bubbles, backpressure, mid-sort reset, dup flag.
module tb_mesh_loader;

  localparam int N  = 64;
  localparam int W  = 12;
  localparam int SC = 53;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_pkt = '0;
  logic [N*W-1:0] load_bus;
  logic           load_en;
  logic           sort_en;
  logic           done;
  logic           busy;
  logic           dup_err;

  int checks = 0;
  int errors = 0;

  mesh_loader dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pkt   (in_pkt),
    .load_bus (load_bus),
    .load_en  (load_en),
    .sort_en  (sort_en),
    .done     (done),
    .busy     (busy),
    .dup_err  (dup_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] pkt_of(int k, int mode);
    logic [5:0] a;
    logic [5:0] d;
    a = 6'(k);
    if (mode == 1 && k == 10) a = 6'd5;
    d = 6'(63 - k);
    return {a, d};
  endfunction

  function automatic int bad_slots(int mode);
    int b = 0;
    for (int k = 0; k < N; k++)
      if (load_bus[k*W +: W] !== pkt_of(k, mode)) b++;
    return b;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_frame(input int mode, input bit bubbles);
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      in_pkt   = pkt_of(k, mode);
      @(negedge clk);
      if (bubbles && k != N - 1) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  // Called on the load_en cycle (n=1); returns the cycle index of done.
  task automatic run_sort(output int n_done, output int n_sort);
    n_done = -1;
    n_sort = 0;
    for (int n = 1; n <= 200; n++) begin
      if (sort_en) n_sort++;
      if (done) begin
        n_done = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, load_en, sort_en, done, busy} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 10000",
               {in_ready, load_en, sort_en, done, busy});
    end
    checks++;
    if (load_bus !== '0) begin
      errors++;
      $display("FAIL reset_bus: got nonzero expected zero");
    end
    checks++;
    if (dup_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_dup: got %b expected 0", dup_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_full_frame();
    int nd, ns, bs;
    send_frame(0, 1'b0);
    checks++;
    if ({load_en, busy, in_ready} !== 3'b110) begin
      errors++;
      $display("FAIL full_commit: got %b expected 110",
               {load_en, busy, in_ready});
    end
    run_sort(nd, ns);
    checks++;
    if (nd != SC + 2) begin
      errors++;
      $display("FAIL full_done_lat: got %0d expected %0d", nd, SC + 2);
    end
    checks++;
    if (ns != SC) begin
      errors++;
      $display("FAIL full_sort_len: got %0d expected %0d", ns, SC);
    end
    bs = bad_slots(0);
    checks++;
    if (bs != 0) begin
      errors++;
      $display("FAIL full_bus: got %0d bad slots expected 0", bs);
    end
    @(negedge clk);
    checks++;
    if ({in_ready, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL full_back_fill: got %b expected 100",
               {in_ready, busy, done});
    end
  endtask

  task automatic test_bubbles();
    int nd, ns, bs;
    do_reset();
    send_frame(0, 1'b1);
    checks++;
    if (load_en !== 1'b1) begin
      errors++;
      $display("FAIL bub_commit: got %b expected 1", load_en);
    end
    run_sort(nd, ns);
    checks++;
    if (nd != SC + 2 || ns != SC) begin
      errors++;
      $display("FAIL bub_timing: got done %0d sort %0d expected %0d %0d",
               nd, ns, SC + 2, SC);
    end
    bs = bad_slots(0);
    checks++;
    if (bs != 0) begin
      errors++;
      $display("FAIL bub_bus: got %0d bad slots expected 0", bs);
    end
    @(negedge clk);
  endtask

  task automatic test_dup_check();
    int nd, ns, bs;
    logic exp_dup;
`ifdef MESH_LOADER_DUP_CHECK_EN
    exp_dup = 1'b1;
`else
    exp_dup = 1'b0;
`endif
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      in_pkt   = pkt_of(k, 1);
      @(negedge clk);
      if (k == 9) begin
        checks++;
        if (dup_err !== 1'b0) begin
          errors++;
          $display("FAIL dup_before: got %b expected 0", dup_err);
        end
      end
      if (k == 10) begin
        checks++;
        if (dup_err !== exp_dup) begin
          errors++;
          $display("FAIL dup_set: got %b expected %b", dup_err, exp_dup);
        end
      end
    end
    in_valid = 1'b0;
    run_sort(nd, ns);
    checks++;
    if (nd != SC + 2 || ns != SC) begin
      errors++;
      $display("FAIL dup_timing: got done %0d sort %0d expected %0d %0d",
               nd, ns, SC + 2, SC);
    end
    bs = bad_slots(1);
    checks++;
    if (bs != 0) begin
      errors++;
      $display("FAIL dup_bus: got %0d bad slots expected 0", bs);
    end
    @(negedge clk);
    checks++;
    if (dup_err !== exp_dup) begin
      errors++;
      $display("FAIL dup_sticky: got %b expected %b", dup_err, exp_dup);
    end
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      in_pkt   = pkt_of(k, 0);
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (dup_err !== 1'b0) begin
          errors++;
          $display("FAIL dup_clear: got %b expected 0", dup_err);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (dup_err !== 1'b0) begin
      errors++;
      $display("FAIL dup_clean_frame: got %b expected 0", dup_err);
    end
    run_sort(nd, ns);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int  bs;
    bit  ready_seen;
    bit  done_seen;
    send_frame(0, 1'b0);
    repeat (3) @(negedge clk);
    in_valid   = 1'b1;
    in_pkt     = 12'hABC;
    ready_seen = 1'b0;
    done_seen  = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (in_ready) ready_seen = 1'b1;
      if (done) begin
        done_seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (ready_seen || !done_seen) begin
      errors++;
      $display("FAIL bp_ready: got ready %b done %b expected 0 1",
               ready_seen, done_seen);
    end
    bs = bad_slots(0);
    checks++;
    if (bs != 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d bad slots expected 0", bs);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_after: got %b expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (load_bus[0 +: W] !== 12'hABC) begin
      errors++;
      $display("FAIL bp_slot0: got %h expected abc", load_bus[0 +: W]);
    end
    checks++;
    if (load_bus[W +: W] !== pkt_of(1, 0)) begin
      errors++;
      $display("FAIL bp_slot1: got %h expected %h",
               load_bus[W +: W], pkt_of(1, 0));
    end
  endtask

  task automatic test_reset_mid_sort();
    int  cnt;
    int  nd, ns, bs;
    bit  done_seen;
    do_reset();
    send_frame(0, 1'b0);
    cnt = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (sort_en) cnt++;
      if (cnt == 20) break;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({sort_en, in_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL rms_state: got %b expected 010",
               {sort_en, in_ready, busy});
    end
    checks++;
    if (load_bus !== '0) begin
      errors++;
      $display("FAIL rms_bus: got nonzero expected zero");
    end
    done_seen = 1'b0;
    repeat (80) begin
      if (done || sort_en) done_seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (done_seen) begin
      errors++;
      $display("FAIL rms_no_done: got activity expected idle");
    end
    send_frame(0, 1'b0);
    checks++;
    if (load_en !== 1'b1) begin
      errors++;
      $display("FAIL rms_commit: got %b expected 1", load_en);
    end
    run_sort(nd, ns);
    checks++;
    if (nd != SC + 2 || ns != SC) begin
      errors++;
      $display("FAIL rms_timing: got done %0d sort %0d expected %0d %0d",
               nd, ns, SC + 2, SC);
    end
    bs = bad_slots(0);
    checks++;
    if (bs != 0) begin
      errors++;
      $display("FAIL rms_bus: got %0d bad slots expected 0", bs);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_bubbles();
    test_dup_check();
    test_backpressure();
    test_reset_mid_sort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
